// File: rtl/rr_grant_arbiter4.sv
`default_nettype none
// ============================================================================
// Module      : rr_grant_arbiter4
// Description : Four-way round-robin arbiter with a registered one-hot grant
//               and its binary index. The holder keeps the grant while it
//               requests. When MAX_HOLD is nonzero and others are waiting,
//               the holder is forced off after MAX_HOLD consecutive cycles,
//               and preempt flags that handoff.
// Ports       : clk       - clock, rising edge
//               rst       - asynchronous active-high reset
//               req[3:0]  - request vector, one bit per requester
//               gnt[3:0]  - registered one-hot grant, zero when idle
//               gnt_id    - index of the granted requester (valid with gnt_valid)
//               gnt_valid - high when any grant bit is set
//               preempt   - one-cycle pulse on a grant forced by hold expiry
// Revision    : 1.0 - initial release
// ============================================================================
module rr_grant_arbiter4 #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_valid,
    output logic       preempt
);

    localparam logic [0:0] c_st_idle  = 1'b0;
    localparam logic [0:0] c_st_grant = 1'b1;

    // Value of the hold counter on the holder's last allowed cycle.
    localparam logic [7:0] c_hold_last = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);
    localparam bit         c_limit_on  = (MAX_HOLD != 0);

    logic [0:0] r_state;
    logic [1:0] r_ptr;
    logic [7:0] r_hold_cnt;
    logic [3:0] r_gnt;
    logic [1:0] r_gnt_id;
    logic       r_gnt_valid;
    logic       r_preempt;

    logic [3:0] w_other;
    logic       w_holder_req;
    logic       w_hold_exp;
    logic [3:0] w_src;
    logic [1:0] w_pick_idx;
    logic       w_pick_found;
    logic [1:0] w_cand;

    // While granting, r_gnt is onehot(holder), so masking with it removes the holder.
    assign w_other      = req & ~r_gnt;
    assign w_holder_req = |(req & r_gnt);
    assign w_hold_exp   = c_limit_on && (r_hold_cnt == c_hold_last);

    // One search unit serves both states: in IDLE it scans all requests,
    // in GRANT it scans only the non-holders.
    always_comb begin
        w_src        = (r_state == c_st_idle) ? req : w_other;
        w_pick_idx   = r_ptr;
        w_pick_found = 1'b0;
        w_cand       = r_ptr;
        // Scan from the farthest offset down so the closest to r_ptr wins.
        for (int k = 3; k >= 0; k--) begin
            w_cand = r_ptr + 2'(k);
            if (w_src[w_cand]) begin
                w_pick_idx   = w_cand;
                w_pick_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_ptr       <= 2'd0;
            r_hold_cnt  <= 8'd0;
            r_gnt       <= 4'b0000;
            r_gnt_id    <= 2'd0;
            r_gnt_valid <= 1'b0;
            r_preempt   <= 1'b0;
        end else begin
            r_preempt <= 1'b0;
            if (r_state == c_st_idle) begin
                if (w_pick_found) begin
                    r_state     <= c_st_grant;
                    r_gnt       <= 4'b0001 << w_pick_idx;
                    r_gnt_id    <= w_pick_idx;
                    r_gnt_valid <= 1'b1;
                    r_ptr       <= w_pick_idx + 2'd1;
                    r_hold_cnt  <= 8'd0;
                end
            end else begin
                if (!w_holder_req) begin
                    if (w_pick_found) begin
                        // Direct handoff, no idle bubble.
                        r_gnt       <= 4'b0001 << w_pick_idx;
                        r_gnt_id    <= w_pick_idx;
                        r_ptr       <= w_pick_idx + 2'd1;
                        r_hold_cnt  <= 8'd0;
                    end else begin
                        // Pointer already sits one past the old holder.
                        r_state     <= c_st_idle;
                        r_gnt       <= 4'b0000;
                        r_gnt_id    <= 2'd0;
                        r_gnt_valid <= 1'b0;
                        r_hold_cnt  <= 8'd0;
                    end
                end else if (w_hold_exp) begin
                    if (w_pick_found) begin
                        r_gnt       <= 4'b0001 << w_pick_idx;
                        r_gnt_id    <= w_pick_idx;
                        r_ptr       <= w_pick_idx + 2'd1;
                        r_hold_cnt  <= 8'd0;
                        r_preempt   <= 1'b1;
                    end else begin
                        // Uncontended: keep the grant and restart the window.
                        r_hold_cnt  <= 8'd0;
                    end
                end else if (r_hold_cnt != 8'hFF) begin
                    r_hold_cnt <= r_hold_cnt + 8'd1;
                end
            end
        end
    end

    assign gnt       = r_gnt;
    assign gnt_id    = r_gnt_id;
    assign gnt_valid = r_gnt_valid;
    assign preempt   = r_preempt;

endmodule
`default_nettype wire

// File: tb/tb_rr_grant_arbiter4.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_grant_arbiter4
// Description : Scoreboard bench for rr_grant_arbiter4 (MAX_HOLD = 4). The
//               stimulus process queues the expected outputs for each edge;
//               a monitor process pops and compares them after each edge or
//               after an asynchronous reset pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_grant_arbiter4;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       preempt;

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] id;
        logic       valid;
        logic       pre;
        string      tag;
    } exp_t;

    exp_t q_exp[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    event ev_async;

    rr_grant_arbiter4 #(.MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .preempt   (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input string field,
                         input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %0h, want %0h at %0t", tag, field, act, exp, $time);
        end
    endtask

    task automatic push(input logic [3:0] eg, input logic [1:0] ei,
                        input logic ep, input string tag);
        exp_t e;
        e.gnt   = eg;
        e.id    = ei;
        e.valid = |eg;
        e.pre   = ep;
        e.tag   = tag;
        q_exp.push_back(e);
    endtask

    // Drive req for the next edge and queue what that edge must produce.
    task automatic step(input logic [3:0] r, input logic [3:0] eg,
                        input logic [1:0] ei, input logic ep, input string tag);
        @(negedge clk);
        req = r;
        push(eg, ei, ep, tag);
    endtask

    // Monitor: one expectation per clock edge or asynchronous check event.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or ev_async);
            #1;
            if (q_exp.size() > 0) begin
                e = q_exp.pop_front();
                check(e.tag, "gnt",       {4'b0, gnt},       {4'b0, e.gnt});
                check(e.tag, "gnt_valid", {7'b0, gnt_valid}, {7'b0, e.valid});
                check(e.tag, "preempt",   {7'b0, preempt},   {7'b0, e.pre});
                if (e.valid)
                    check(e.tag, "gnt_id", {6'b0, gnt_id}, {6'b0, e.id});
            end
        end
    end

    initial begin
        logic [1:0] idx;
        logic [3:0] oh;
        rst = 1'b1;
        req = 4'b0000;

        // T1: reset held with all requesting, then release.
        repeat (2) @(negedge clk);
        req = 4'b1111;
        #2;
        push(4'b0000, 2'd0, 1'b0, "t1_in_reset");
        ->ev_async;
        #2;
        @(negedge clk);
        rst = 1'b0;
        push(4'b0001, 2'd0, 1'b0, "t1_first_grant");

        // T3: rotation under constant full contention, MAX_HOLD = 4.
        repeat (3) step(4'b1111, 4'b0001, 2'd0, 1'b0, "t3_hold0");
        for (int g = 1; g <= 4; g++) begin
            idx = 2'(g % 4);
            oh  = 4'b0001 << idx;
            step(4'b1111, oh, idx, 1'b1, "t3_preempt");
            if (g < 4)
                repeat (3) step(4'b1111, oh, idx, 1'b0, "t3_hold");
        end

        // T4: sole holder 1 is never preempted.
        step(4'b0010, 4'b0010, 2'd1, 1'b0, "t4_handoff");
        repeat (19) step(4'b0010, 4'b0010, 2'd1, 1'b0, "t4_sole");

        // T2: go idle, then single requester 2 for five edges, then drop.
        step(4'b0000, 4'b0000, 2'd0, 1'b0, "t2_idle");
        repeat (5) step(4'b0100, 4'b0100, 2'd2, 1'b0, "t2_single");
        step(4'b0000, 4'b0000, 2'd0, 1'b0, "t2_release");
        step(4'b0000, 4'b0000, 2'd0, 1'b0, "t2_stay_idle");

        // T5: holder 0 with req 1001 (ptr is 3 after T2, so grant 0 alone first).
        step(4'b0001, 4'b0001, 2'd0, 1'b0, "t5_grant0");
        step(4'b1001, 4'b0001, 2'd0, 1'b0, "t5_hold0");
        step(4'b1000, 4'b1000, 2'd3, 1'b0, "t5_handoff3");
        step(4'b1000, 4'b1000, 2'd3, 1'b0, "t5_hold3");

        // T6: move to holder 2, then asynchronous reset between edges.
        step(4'b0100, 4'b0100, 2'd2, 1'b0, "t6_grant2");
        @(negedge clk);
        #2;
        rst = 1'b1;
        push(4'b0000, 2'd0, 1'b0, "t6_async_rst");
        ->ev_async;
        #2;
        rst = 1'b0;
        req = 4'b1010;
        push(4'b0010, 2'd1, 1'b0, "t6_ptr_restart");
        step(4'b1010, 4'b0010, 2'd1, 1'b0, "t6_hold1");
        step(4'b0000, 4'b0000, 2'd0, 1'b0, "t6_release");

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 20 && q_exp.size() > 0; i++) begin
            @(posedge clk);
            #2;
        end
        n_checks++;
        if (q_exp.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending, want 0", q_exp.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
